// File: rtl/fp_mult_if.sv
// fp_mult_if: operand/result valid-ready bundle for fp_mult_pipe.
// The slave modport is the multiplier side; master is the producer/consumer side.
interface fp_mult_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage floating-point multiplier (unpack, mantissa product, normalise/round/pack).
// Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic      clk,
   input logic      rst_n,
   fp_mult_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]         QNAN = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fp_class_e;

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      fp_class_e c;
      c = CL_NORM;
      if (e == '0)
         c = CL_ZERO;
      else if (e == '1)
         c = (m == '0) ? CL_INF : CL_NAN;
      return c;
   endfunction

   logic en;

   // Stage 1: classify and unpack
   logic                    sa, sb;
   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        ma, mb;
   fp_class_e               ca, cb;
   logic                    spec1_d;
   logic [W-1:0]            res1_d;
   logic [3:0]              flg1_d;
   logic signed [XW-1:0]    exp1_d;

   logic                    v1_q, spec1_q, sign1_q;
   logic [W-1:0]            res1_q;
   logic [3:0]              flg1_q;
   logic signed [XW-1:0]    exp1_q;
   logic [MAN_W:0]          ma1_q, mb1_q;

   logic                    v2_q, spec2_q, sign2_q;
   logic [W-1:0]            res2_q;
   logic [3:0]              flg2_q;
   logic signed [XW-1:0]    exp2_q;
   logic [PW-1:0]           prod2_q;

   logic                    v3_q;
   logic [W-1:0]            res3_q, res3_d;
   logic [3:0]              flg3_q, flg3_d;

   assign {sa, ea, ma} = bus.a;
   assign {sb, eb, mb} = bus.b;
   assign ca = classify(ea, ma);
   assign cb = classify(eb, mb);
   assign exp1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   always_comb begin
      spec1_d = 1'b1;
      res1_d  = '0;
      flg1_d  = '0;
      if (ca == CL_NAN || cb == CL_NAN ||
          (ca == CL_ZERO && cb == CL_INF) || (ca == CL_INF && cb == CL_ZERO)) begin
         res1_d = QNAN;
         flg1_d = 4'b1000;
      end else if (ca == CL_INF || cb == CL_INF) begin
         res1_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (ca == CL_ZERO || cb == CL_ZERO) begin
         res1_d = {sa ^ sb, {(W-1){1'b0}}};
      end else begin
         spec1_d = 1'b0;
      end
   end

   // Stage 3: normalise by at most one bit, round, then range-check the final exponent
   logic                    top, guard, sticky, inexact;
   logic [MAN_W-1:0]        frac, frac_r;
   logic signed [XW-1:0]    exp_n, exp_r;

   always_comb begin
      top     = prod2_q[PW-1];
      frac    = top ? prod2_q[PW-2 -: MAN_W] : prod2_q[PW-3 -: MAN_W];
      guard   = top ? prod2_q[MAN_W]         : prod2_q[MAN_W-1];
      sticky  = top ? |prod2_q[MAN_W-1:0]    : |prod2_q[MAN_W-2:0];
      inexact = guard | sticky;
      exp_n   = exp2_q + $signed({{(XW-1){1'b0}}, top});
`ifdef FP_MULT_RNE_EN
      begin : rne
         logic carry;
         {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
         exp_r = exp_n + $signed({{(XW-1){1'b0}}, carry});
      end
`else
      frac_r = frac;
      exp_r  = exp_n;
`endif
      res3_d = {sign2_q, exp_r[EXP_W-1:0], frac_r};
      flg3_d = {3'b000, inexact};
      if (spec2_q) begin
         res3_d = res2_q;
         flg3_d = flg2_q;
      end else if (exp_r >= EMAX) begin
         res3_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg3_d = 4'b0101;
      end else if (exp_r[XW-1] || exp_r == '0) begin
         res3_d = {sign2_q, {(W-1){1'b0}}};
         flg3_d = 4'b0011;
      end
   end

   // One shared enable: a stalled output freezes every stage, bubbles included
   assign en = !v3_q || bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         spec1_q <= 1'b0;
         sign1_q <= 1'b0;
         res1_q  <= '0;
         flg1_q  <= '0;
         exp1_q  <= '0;
         ma1_q   <= '0;
         mb1_q   <= '0;
         v2_q    <= 1'b0;
         spec2_q <= 1'b0;
         sign2_q <= 1'b0;
         res2_q  <= '0;
         flg2_q  <= '0;
         exp2_q  <= '0;
         prod2_q <= '0;
         v3_q    <= 1'b0;
         res3_q  <= '0;
         flg3_q  <= '0;
      end else if (en) begin
         v1_q    <= bus.in_valid;
         spec1_q <= spec1_d;
         sign1_q <= sa ^ sb;
         res1_q  <= res1_d;
         flg1_q  <= flg1_d;
         exp1_q  <= exp1_d;
         ma1_q   <= {1'b1, ma};
         mb1_q   <= {1'b1, mb};
         v2_q    <= v1_q;
         spec2_q <= spec1_q;
         sign2_q <= sign1_q;
         res2_q  <= res1_q;
         flg2_q  <= flg1_q;
         exp2_q  <= exp1_q;
         prod2_q <= PW'(ma1_q) * PW'(mb1_q);
         v3_q    <= v2_q;
         res3_q  <= res3_d;
         flg3_q  <= flg3_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = v3_q;
   assign bus.result    = res3_q;
   assign bus.flags     = flg3_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed vectors, randomized scoreboard against an arithmetic
// reference model, stall/back-to-back flow, and reset with work in flight (single + double).
module tb_fp_mult_pipe;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

`ifdef FP_MULT_RNE_EN
   localparam logic [31:0] R_RND = 32'h40100002;
`else
   localparam logic [31:0] R_RND = 32'h40100001;
`endif

   fp_mult_if #(.EXP_W(8),  .MAN_W(23)) sif ();
   fp_mult_if #(.EXP_W(11), .MAN_W(52)) dif ();

   fp_mult_pipe #(.EXP_W(8),  .MAN_W(23)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sif));
   fp_mult_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (.clk(clk), .rst_n(rst_n), .bus(dif));

   always #5 clk = ~clk;

   // Reference: exact integer product, scaled and rounded by plain arithmetic. Returns {flags, result}.
   function automatic logic [67:0] fp_ref(input logic [63:0] a, input logic [63:0] b,
                                          input int E, input int M);
      logic         sa, sb, s;
      longint       ea, eb, e, emax, bias;
      logic [63:0]  ma, mb, res, mmask;
      logic [127:0] p, mant, rem;
      logic [3:0]   fl;
      int           sh, w;
      w     = 1 + E + M;
      emax  = (longint'(1) << E) - 1;
      bias  = (longint'(1) << (E - 1)) - 1;
      mmask = (64'd1 << M) - 1;
      sa = a[w-1];
      sb = b[w-1];
      s  = sa ^ sb;
      ea = longint'((a >> M) & 64'(emax));
      eb = longint'((b >> M) & 64'(emax));
      ma = a & mmask;
      mb = b & mmask;
      fl = 4'b0000;
      if ((ea == emax && ma != 0) || (eb == emax && mb != 0) ||
          (ea == 0 && eb == emax) || (ea == emax && eb == 0)) begin
         res = (64'd1 << (w - 1)) - 1;
         fl  = 4'b1000;
      end else if (ea == emax || eb == emax) begin
         res = (64'(s) << (w - 1)) | (64'(emax) << M);
      end else if (ea == 0 || eb == 0) begin
         res = 64'(s) << (w - 1);
      end else begin
         p    = 128'(ma | (64'd1 << M)) * 128'(mb | (64'd1 << M));
         sh   = (p >= (128'd1 << (2 * M + 1))) ? 1 : 0;
         mant = p >> (M + sh);
         rem  = p & ((128'd1 << (M + sh)) - 1);
         e    = ea + eb - bias + sh;
`ifdef FP_MULT_RNE_EN
         begin : rnd
            logic [127:0] half;
            half = 128'd1 << (M + sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 1;
            if (mant == (128'd1 << (M + 1))) begin
               mant = mant >> 1;
               e    = e + 1;
            end
         end
`endif
         if (e >= emax) begin
            res = (64'(s) << (w - 1)) | (64'(emax) << M);
            fl  = 4'b0101;
         end else if (e <= 0) begin
            res = 64'(s) << (w - 1);
            fl  = 4'b0011;
         end else begin
            res = (64'(s) << (w - 1)) | (64'(e) << M) | (mant[63:0] & mmask);
            fl  = {3'b000, rem != '0};
         end
      end
      return {fl, res};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [7:0]  e;
      logic [22:0] m;
      int unsigned sel;
      sel = $urandom_range(0, 15);
      m   = 23'($urandom);
      case (sel)
         0: e = 8'd0;
         1: begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) m = '0;
         end
         2: e = 8'($urandom_range(1, 40));
         3: e = 8'($urandom_range(215, 254));
         4: begin
            e = 8'($urandom_range(110, 144));
            m = '1;
         end
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, m};
   endfunction

   task automatic test_reset();
      int lat;
      rst_n = 1'b0;
      sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.out_ready = 1'b1;
      dif.in_valid = 1'b0; dif.a = '0; dif.b = '0; dif.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", sif.out_valid); end
      checks++; if (sif.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", sif.result); end
      checks++; if (sif.flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b want=0000", sif.flags); end
      checks++; if (sif.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", sif.in_ready); end
      checks++; if (dif.out_valid !== 1'b0 || dif.result !== 64'h0) begin failures++; $display("FAIL reset_dbl got=%b/%h want=0/0", dif.out_valid, dif.result); end
      // release and present an operand for the very first rising edge
      rst_n = 1'b1;
      sif.in_valid = 1'b1; sif.a = 32'h3FC00000; sif.b = 32'h40000000;
      #1;
      checks++; if (sif.in_ready !== 1'b1) begin failures++; $display("FAIL first_accept_ready got=%b want=1", sif.in_ready); end
      @(negedge clk);
      sif.in_valid = 1'b0;
      lat = 1;
      while (sif.out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      checks++; if (lat != 3) begin failures++; $display("FAIL first_latency got=%0d want=3", lat); end
      checks++; if (sif.result !== 32'h40400000) begin failures++; $display("FAIL first_result got=%h want=40400000", sif.result); end
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] va [10] = '{32'h3FC00000, 32'h3FC00001, 32'h00000000, 32'hFF800000, 32'h80000000,
                               32'h7F000000, 32'h00800000, 32'h7FC00000, 32'h00000001, 32'h80000000};
      logic [31:0] vb [10] = '{32'h40000000, 32'h3FC00001, 32'h7F800000, 32'h40000000, 32'h3F800000,
                               32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h00000000};
      logic [31:0] vr [10] = '{32'h40400000, R_RND,        32'h7FFFFFFF, 32'hFF800000, 32'h80000000,
                               32'h7F800000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 32'h80000000};
      logic [3:0]  vf [10] = '{4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0000,
                               4'b0101, 4'b0011, 4'b1000, 4'b0000, 4'b0000};
      int lat;
      sif.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sif.in_valid = 1'b1; sif.a = va[i]; sif.b = vb[i];
         @(negedge clk);
         sif.in_valid = 1'b0;
         lat = 1;
         while (sif.out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
         checks++; if (lat != 3) begin failures++; $display("FAIL dir%0d_latency got=%0d want=3", i, lat); end
         checks++; if (sif.result !== vr[i]) begin failures++; $display("FAIL dir%0d_result got=%h want=%h", i, sif.result, vr[i]); end
         checks++; if (sif.flags !== vf[i]) begin failures++; $display("FAIL dir%0d_flags got=%b want=%b", i, sif.flags, vf[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [67:0] q[$];
      logic [67:0] ev;
      logic [31:0] held_r;
      logic [3:0]  held_f;
      logic        stalled = 1'b0;
      int issued = 0;
      int cyc = 0;
      while ((issued < 300 || q.size() != 0) && cyc < 5000) begin
         if (stalled) begin
            checks++; if (sif.out_valid !== 1'b1 || sif.result !== held_r || sif.flags !== held_f) begin
               failures++; $display("FAIL rnd_stall_hold got=%b/%h/%b want=1/%h/%b", sif.out_valid, sif.result, sif.flags, held_r, held_f); end
         end
         sif.out_ready = ($urandom_range(0, 3) != 0);
         sif.in_valid  = (issued < 300) && ($urandom_range(0, 3) != 0);
         sif.a = rnd_op(); sif.b = rnd_op();
         #1;
         checks++; if (sif.in_ready !== (!sif.out_valid || sif.out_ready)) begin
            failures++; $display("FAIL rnd_in_ready got=%b want=%b", sif.in_ready, !sif.out_valid || sif.out_ready); end
         if (sif.in_valid && sif.in_ready) begin
            q.push_back(fp_ref({32'd0, sif.a}, {32'd0, sif.b}, 8, 23));
            issued++;
         end
         if (sif.out_valid && sif.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rnd_spurious got=%h want=none", sif.result);
            end else begin
               ev = q.pop_front();
               if (sif.result !== ev[31:0] || sif.flags !== ev[67:64]) begin
                  failures++; $display("FAIL rnd_result got=%h/%b want=%h/%b", sif.result, sif.flags, ev[31:0], ev[67:64]); end
            end
         end
         stalled = sif.out_valid && !sif.out_ready;
         held_r  = sif.result;
         held_f  = sif.flags;
         @(negedge clk);
         cyc++;
      end
      sif.in_valid = 1'b0; sif.out_ready = 1'b1;
      checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d want=0 pending", q.size()); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [67:0] q[$];
      logic [67:0] ev;
      logic [31:0] held_r;
      logic        stalled = 1'b0;
      int issued = 0;
      int got = 0;
      sif.a = rnd_op(); sif.b = rnd_op();
      for (int c = 0; c < 40 && (issued < 8 || q.size() != 0); c++) begin
         if (stalled) begin
            checks++; if (sif.out_valid !== 1'b1 || sif.result !== held_r) begin
               failures++; $display("FAIL b2b_stall_hold c=%0d got=%b/%h want=1/%h", c, sif.out_valid, sif.result, held_r); end
         end
         sif.out_ready = !(c >= 4 && c <= 6);
         sif.in_valid  = (issued < 8);
         #1;
         if (c >= 4 && c <= 6) begin
            checks++; if (sif.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready c=%0d got=%b want=0", c, sif.in_ready); end
         end
         if (sif.out_valid && sif.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL b2b_duplicate got=%h want=none", sif.result);
            end else begin
               ev = q.pop_front();
               got++;
               if (sif.result !== ev[31:0] || sif.flags !== ev[67:64]) begin
                  failures++; $display("FAIL b2b_result n=%0d got=%h/%b want=%h/%b", got, sif.result, sif.flags, ev[31:0], ev[67:64]); end
            end
         end
         stalled = sif.out_valid && !sif.out_ready;
         held_r  = sif.result;
         if (sif.in_valid && sif.in_ready) begin
            q.push_back(fp_ref({32'd0, sif.a}, {32'd0, sif.b}, 8, 23));
            issued++;
            @(negedge clk);
            sif.a = rnd_op(); sif.b = rnd_op();
         end else begin
            @(negedge clk);
         end
      end
      sif.in_valid = 1'b0; sif.out_ready = 1'b1;
      checks++; if (got != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", got); end
      @(negedge clk);
   endtask

   task automatic test_reset_in_flight();
      int bad = 0;
      int lat;
      sif.out_ready = 1'b1; dif.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sif.in_valid = 1'b1; sif.a = rnd_op(); sif.b = rnd_op();
         dif.in_valid = 1'b1; dif.a = 64'h3FF8000000000000; dif.b = 64'h4000000000000000;
         @(negedge clk);
      end
      sif.in_valid = 1'b0; dif.in_valid = 1'b0;
      checks++; if (sif.out_valid !== 1'b1 || dif.out_valid !== 1'b1) begin
         failures++; $display("FAIL inflight_valid got=%b/%b want=1/1", sif.out_valid, dif.out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (sif.out_valid !== 1'b0 || dif.out_valid !== 1'b0) begin
         failures++; $display("FAIL rst_out_valid got=%b/%b want=0/0", sif.out_valid, dif.out_valid); end
      checks++; if (sif.result !== 32'h0 || dif.result !== 64'h0 || sif.flags !== 4'h0) begin
         failures++; $display("FAIL rst_result got=%h/%h/%b want=0/0/0", sif.result, dif.result, sif.flags); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (sif.out_valid !== 1'b0 || dif.out_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rst_stale got=%0d want=0 cycles", bad); end
      sif.in_valid = 1'b1; sif.a = 32'h3FC00000; sif.b = 32'h40000000;
      dif.in_valid = 1'b1; dif.a = 64'h3FF8000000000000; dif.b = 64'h4000000000000000;
      @(negedge clk);
      sif.in_valid = 1'b0; dif.in_valid = 1'b0;
      lat = 1;
      while (dif.out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      checks++; if (lat != 3) begin failures++; $display("FAIL dbl_latency got=%0d want=3", lat); end
      checks++; if (dif.result !== 64'h4008000000000000 || dif.flags !== 4'h0) begin
         failures++; $display("FAIL dbl_result got=%h/%b want=4008000000000000/0000", dif.result, dif.flags); end
      checks++; if (sif.out_valid !== 1'b1 || sif.result !== 32'h40400000) begin
         failures++; $display("FAIL post_rst_single got=%b/%h want=1/40400000", sif.out_valid, sif.result); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_in_flight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
